// File: rtl/im_boot_loader.sv
// Byte-stream loader for the MIPS instruction memory: parses a big-endian length
// header, assembles 32-bit words, writes them to IM and holds the CPU in reset until done.
//
// state  | meaning
// LEN_HI | waiting for length high byte
// LEN_LO | waiting for length low byte, range-checks N
// DATA   | assembling/writing words (one bubble per im_we)
// DONE   | image written, CPU released, input ignored
// ERR    | length out of range, CPU held in reset
module im_boot_loader #(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(IM_DEPTH);

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign len_full  = {len_hi_q, in_data};
  assign last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LEN_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      words_q  <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                state_d = S_DONE;
          else if ({1'b0, len_full} > DEPTH_L)  state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA:   if (we_q && last_word) state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_LEN_HI;
    endcase
  end

  // Datapath: the fourth byte of a word goes straight into wdata so the write
  // lands one cycle after it transfers.
  always_comb begin
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    words_d  = words_q;
    unique case (state_q)
      S_LEN_HI: if (xfer) len_hi_d = in_data;
      S_LEN_LO: if (xfer) len_d = len_full;
      S_DATA: begin
        if (we_q) words_d = words_q + 1'b1;
        if (xfer) begin
          cnt_d  = cnt_q + 2'd1;
          word_d = {word_q[15:0], in_data};
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = {word_q, in_data};
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_rst   = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    unique case (state_q)
      S_LEN_HI: in_ready = 1'b1;
      S_LEN_LO: in_ready = 1'b1;
      S_DATA:   in_ready = !we_q;
      S_DONE: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:    load_err = 1'b1;
      default: ;
    endcase
  end

  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized bench for im_boot_loader: a byte-count based reference model predicts
// every output each cycle; literal checks pin key results of the directed images.
module tb_im_boot_loader;

  localparam int IM_DEPTH = 1024;
  localparam int ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  im_boot_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from how many bytes have been accepted.
  int          nbytes;
  int          n_len;
  logic [7:0]  hist [0:4200];
  logic        m_ready, m_we, m_done, m_err;
  logic [31:0] m_addr, m_wdata;
  int          m_words;

  always @(posedge clk) begin
    logic xfer;
    int   di;
    if (rst) begin
      nbytes = 0; n_len = 0;
      m_we = 0; m_done = 0; m_err = 0; m_words = 0;
      m_addr = 0; m_wdata = 0; m_ready = 1;
    end else begin
      xfer = in_valid && m_ready;
      if (m_we) begin
        m_words++;
        if (m_words == n_len) m_done = 1;
      end
      m_we = 0;
      if (xfer) begin
        hist[nbytes] = in_data;
        if (nbytes == 1) begin
          n_len = hist[0] * 256 + hist[1];
          if (n_len == 0) m_done = 1;
          else if (n_len > IM_DEPTH) m_err = 1;
        end else if (nbytes >= 2 && (nbytes - 2) % 4 == 3) begin
          di = nbytes - 3;
          m_we    = 1;
          m_addr  = (nbytes - 2) / 4;
          m_wdata = {hist[di], hist[di+1], hist[di+2], hist[di+3]};
        end
        nbytes++;
      end
      m_ready = !m_done && !m_err && !m_we;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("im_we", 32'(im_we), 32'(m_we));
      check("im_addr", 32'(im_addr), m_addr);
      check("im_wdata", im_wdata, m_wdata);
      check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_err", 32'(load_err), 32'(m_err));
      check("words_loaded", 32'(words_loaded), 32'(m_words));
    end
  end

  logic [31:0] dut_mem [0:IM_DEPTH-1];
  always @(negedge clk) if (im_we) dut_mem[im_addr] = im_wdata;

  task automatic send(input logic [7:0] b);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst(input logic with_valid);
    rst      = 1'b1;
    in_valid = with_valid;
    in_data  = 8'hA5;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img [], input int gap_mode);
    foreach (img[i]) begin
      send(img[i]);
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    logic [7:0] img [];
    logic [7:0] b;
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;

    // Two-word load, in_valid held high
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h14, 8'hAC, 8'h08, 8'h00, 8'h50};
    send_image(img, 0);
    @(negedge clk);
    check("two_word_we_t1", 32'(im_we), 32'd1);
    check("two_word_done_t1", 32'(load_done), 32'd0);
    @(negedge clk);
    check("two_word_done_t2", 32'(load_done), 32'd1);
    check("two_word_cpu_rst_t2", 32'(cpu_rst), 32'd0);
    check("two_word_mem0", dut_mem[0], 32'h20080014);
    check("two_word_mem1", dut_mem[1], 32'hAC080050);
    check("two_word_count", 32'(words_loaded), 32'd2);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Same image with gaps
    pulse_rst(1'b0);
    dut_mem[0] = '0; dut_mem[1] = '0;
    send_image(img, 1);
    idle(2);
    check("gap_mem0", dut_mem[0], 32'h20080014);
    check("gap_mem1", dut_mem[1], 32'hAC080050);

    // Zero length
    pulse_rst(1'b0);
    img = '{8'h00, 8'h00};
    send_image(img, 0);
    @(negedge clk);
    check("zero_done", 32'(load_done), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    idle(3);

    // Over range
    pulse_rst(1'b0);
    img = '{8'h04, 8'h01};
    send_image(img, 0);
    @(negedge clk);
    check("over_err", 32'(load_err), 32'd1);
    check("over_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (8) begin in_data = 8'($urandom); @(posedge clk); #1; end
    in_valid = 1'b0;

    // Exact depth
    pulse_rst(1'b0);
    send(8'h04); send(8'h00);
    for (int i = 0; i < 4 * IM_DEPTH; i++) begin
      if (i >= 4 * IM_DEPTH - 4) b = (i == 4 * IM_DEPTH - 4) ? 8'hAB :
                                     (i == 4 * IM_DEPTH - 3) ? 8'hCD : 8'h00;
      else b = 8'($urandom);
      send(b);
    end
    idle(2);
    check("exact_last_word", dut_mem[IM_DEPTH-1], 32'hABCD0000);
    check("exact_count", 32'(words_loaded), 32'd1024);
    check("exact_done", 32'(load_done), 32'd1);

    // Reset mid-load, with a byte offered during reset
    pulse_rst(1'b0);
    img = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_image(img, 0);
    idle(1);
    pulse_rst(1'b1);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_image(img, 0);
    idle(2);
    check("rst_mid_mem0", dut_mem[0], 32'hDEADBEEF);
    check("rst_mid_count", 32'(words_loaded), 32'd1);
    check("rst_mid_done", 32'(load_done), 32'd1);

    // Random images with random gaps
    for (int t = 0; t < 6; t++) begin
      pulse_rst(1'b0);
      n = $urandom_range(1, 8);
      img = new[2 + 4 * n];
      img[0] = 8'(n >> 8);
      img[1] = 8'(n);
      for (int i = 2; i < 2 + 4 * n; i++) img[i] = 8'($urandom);
      send_image(img, 2);
      idle(3);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
